tri2d_mul_acc_pipe: RTL and testbench
=====================================

Name: tri2d_mul_acc_pipe

Overview:
- Parametrised pipelined multiplier / multiply-accumulate unit; next generation of the fixed 12x5 unsigned DSP multiplier used in the tri2d datapath.
- Adds per-operand signedness, configurable latency, a valid sideband, a multiply/accumulate mode with per-sample accumulator restart, and a sticky overflow flag.
- Sits between the tri2d geometry stages (orientation/in-circle partial products) and their consumers.

Parameters:
- A_WIDTH, 12, width of din0.
- B_WIDTH, 5, width of din1.
- A_SIGNED, 0, 1 = din0 is two's complement, 0 = unsigned.
- B_SIGNED, 0, 1 = din1 is two's complement, 0 = unsigned.
- NUM_STAGE, 4, total latency in cycles; legal range 3..8.
- ACC_WIDTH, 24, width of dout and the accumulator; must be >= A_WIDTH+B_WIDTH.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  reset, synchronous, active-low.
- ce  in  1  clock enable; 0 freezes the entire pipeline.
- in_valid  in  1  din0/din1/acc_mode/acc_first are valid this cycle.
- acc_mode  in  1  0 = plain multiply, 1 = accumulate.
- acc_first  in  1  with acc_mode=1: load the accumulator with this product instead of adding.
- din0  in  A_WIDTH  operand A.
- din1  in  B_WIDTH  operand B.
- out_valid  out  1  dout carries a new result.
- dout  out  ACC_WIDTH  product or accumulator value.
- ovf  out  1  sticky accumulator overflow.

Behaviour:
- Reset: on a rising edge with reset=0, all pipeline registers, sideband bits and the accumulator clear; dout=0, out_valid=0, ovf=0. Reset overrides ce. In-flight samples are discarded.
- Pipeline:
  - Stage 1 registers operands and sideband.
  - Stage 2 forms the (A_WIDTH+B_WIDTH)-bit product, extending each operand per its *_SIGNED.
  - Stages 3..NUM_STAGE-1 are pure delay.
  - Stage NUM_STAGE is the output/accumulate register.
- Latency: with ce=1 throughout, a sample presented in cycle t appears on dout/out_valid after the edge ending cycle t+NUM_STAGE-1, i.e. NUM_STAGE edges. Throughput is 1 sample/cycle.
- ce=0: no register changes, including valid, sideband, accumulator and ovf. Outputs hold. Downstream consumes a result only on cycles with ce=1 && out_valid=1.
- Width rule: the product is sign-extended to ACC_WIDTH if A_SIGNED|B_SIGNED, otherwise zero-extended.
- Final stage with valid=1 and acc_mode=0: dout = extended product; accumulator and ovf unchanged.
- Final stage with valid=1, acc_mode=1, acc_first=1: acc = extended product; ovf cleared; dout = acc.
- Final stage with valid=1, acc_mode=1, acc_first=0: acc = acc + extended product, modulo 2^ACC_WIDTH; dout = acc.
  - Overflow sets ovf. For an unsigned configuration, overflow is a carry out. For a signed configuration, overflow is when both addends share a sign that differs from the sum's sign.
  - ovf stays set until the next acc_first or reset.
- Bubble (valid=0) at the final stage: out_valid=0; dout, accumulator and ovf hold.
- acc_first with acc_mode=0 is ignored.
- acc_mode=1, acc_first=0 as the first sample after reset accumulates onto 0.

Decomposition:
- Package tri2d_arith_pkg:
  - default width constants (12, 5, 24);
  - NUM_STAGE min/max constants;
  - function ext_to_acc(value, signed_flag) for extension;
  - function add_ovf(a, b, sum, signed_flag).
- Sub-module tri2d_pipe_delay (WIDTH, DEPTH; clk, reset, ce, d, q): ce-gated, synchronously cleared shift register. Used for the product plus sideband {valid, acc_mode, acc_first} through stages 3..NUM_STAGE-1. DEPTH=0 is a wire.

Test Plan:
- Defaults, acc_mode=0: din0=4095, din1=31, one valid cycle -> 4 edges later dout=126945, out_valid=1 for exactly one cycle, then 0 with dout held.
- A_SIGNED=B_SIGNED=1: (12'hFFF, 5'h1F) -> dout=1. (12'h800, 5'h0F) -> dout=-30720 (24'hFF8800). Both back-to-back, on consecutive cycles.
- acc_mode=1 stream (3,4,first=1), (5,6), (7,8) on consecutive cycles -> dout 12, 42, 98 on three consecutive cycles. Then (2,2,first=1) -> dout=4.
- ce=0 for 3 cycles while 2 samples are in flight -> outputs frozen, results arrive exactly 3 cycles later, values unchanged.
- ACC_WIDTH=18, unsigned: (4095,31,first=1), (4095,31), (4095,31) -> dout 126945, 253890, 118691. ovf rises with the third result and stays 1 until the next acc_first.
- reset=0 for one cycle with 2 samples in flight and acc=98 -> next cycle dout=0, out_valid=0, ovf=0. No stale out_valid ever appears. A following accumulate (1,1,first=0) yields dout=1.

Source files
------------

// File: rtl/tri2d_arith_pkg.sv
// Shared constants and arithmetic helpers for the tri2d multiply/accumulate datapath.
package tri2d_arith_pkg;

  localparam int unsigned DEF_A_WIDTH   = 12;
  localparam int unsigned DEF_B_WIDTH   = 5;
  localparam int unsigned DEF_ACC_WIDTH = 24;
  localparam int unsigned NUM_STAGE_MIN = 3;
  localparam int unsigned NUM_STAGE_MAX = 8;
  localparam int unsigned EXT_MAX       = 64;

  typedef struct packed {
    logic vld;
    logic mode;
    logic first;
  } sband_t;

  // Extends the low 'width' bits of value to EXT_MAX bits, sign or zero per signed_flag.
  function automatic logic [EXT_MAX-1:0] ext_to_acc(input logic [EXT_MAX-1:0] value,
                                                    input int unsigned width,
                                                    input logic signed_flag);
    logic [EXT_MAX-1:0] hi_mask;
    logic [5:0]         msb;
    hi_mask = ~((64'd1 << width) - 64'd1);
    msb     = 6'(width - 1);
    if (signed_flag && value[msb]) return value | hi_mask;
    return value & ~hi_mask;
  endfunction

  // Overflow from the sign bits of both addends and the sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic sum_msb, input logic signed_flag);
    if (signed_flag) return (a_msb == b_msb) && (sum_msb != a_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
  endfunction

endpackage

// File: rtl/tri2d_pipe_delay.sv
// ce-gated, synchronously cleared shift register; DEPTH=0 degenerates to a wire.
module tri2d_pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, ce};
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sr_q <= '0;
      end else if (ce) begin
        sr_q[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/tri2d_mul_acc_pipe.sv
// Pipelined signed/unsigned multiplier with optional accumulate and sticky overflow.
module tri2d_mul_acc_pipe
  import tri2d_arith_pkg::*;
#(
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
  parameter int unsigned A_SIGNED  = 0,
  parameter int unsigned B_SIGNED  = 0,
  parameter int unsigned NUM_STAGE = 4,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 acc_mode,
  input  logic                 acc_first,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 ovf
);

  localparam int unsigned P_W        = A_WIDTH + B_WIDTH;
  localparam int unsigned SB_W       = P_W + $bits(sband_t);
  localparam int unsigned DLY        = NUM_STAGE - 3;
  localparam logic        ANY_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX || ACC_WIDTH < P_W
      || ACC_WIDTH > EXT_MAX) begin : g_bad_cfg
    $error("tri2d_mul_acc_pipe: illegal NUM_STAGE/ACC_WIDTH");
  end

  // Stage 1: operand and sideband capture
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  sband_t             s1_q;

  // Stage 2: product
  logic [EXT_MAX-1:0] a_ext64, b_ext64;
  logic [P_W-1:0]     a_ext, b_ext, prod_d, prod_q;
  sband_t             s2_q;

  assign a_ext64 = ext_to_acc(64'(a_q), A_WIDTH, A_SIGNED != 0);
  assign b_ext64 = ext_to_acc(64'(b_q), B_WIDTH, B_SIGNED != 0);
  assign a_ext   = a_ext64[P_W-1:0];
  assign b_ext   = b_ext64[P_W-1:0];
  // Both operands extended to P_W, so the truncated product is exact for any signedness mix.
  assign prod_d  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      s1_q   <= '0;
      prod_q <= '0;
      s2_q   <= '0;
    end else if (ce) begin
      a_q    <= din0;
      b_q    <= din1;
      s1_q   <= '{vld: in_valid, mode: acc_mode, first: acc_first};
      prod_q <= prod_d;
      s2_q   <= s1_q;
    end
  end

  // Stages 3..NUM_STAGE-1: pure delay
  logic [SB_W-1:0] dly_d, dly_q;
  logic [P_W-1:0]  prod_f;
  sband_t          sb_f;

  assign dly_d = {s2_q, prod_q};

  tri2d_pipe_delay #(
    .WIDTH(SB_W),
    .DEPTH(DLY)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .d    (dly_d),
    .q    (dly_q)
  );

  assign {sb_f, prod_f} = dly_q;

  // Final stage: output / accumulate register
  logic [EXT_MAX-1:0]   prod_ext64;
  logic [ACC_WIDTH-1:0] prod_acc, sum;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d;
  logic                 ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic                 unused_ext;

  assign prod_ext64 = ext_to_acc(64'(prod_f), P_W, ANY_SIGNED);
  assign prod_acc   = prod_ext64[ACC_WIDTH-1:0];
  assign sum        = acc_q + prod_acc;
  assign unused_ext = ^{a_ext64, b_ext64, prod_ext64};

  always_comb begin
    acc_d       = acc_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    out_valid_d = sb_f.vld;
    if (sb_f.vld) begin
      if (!sb_f.mode) begin
        dout_d = prod_acc;
      end else if (sb_f.first) begin
        acc_d  = prod_acc;
        ovf_d  = 1'b0;
        dout_d = prod_acc;
      end else begin
        acc_d  = sum;
        dout_d = sum;
        ovf_d  = ovf_q | add_ovf(acc_q[ACC_WIDTH-1], prod_acc[ACC_WIDTH-1],
                                 sum[ACC_WIDTH-1], ANY_SIGNED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q       <= '0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tri2d_mul_acc_pipe.sv
// Three configurations (unsigned/4 stages, signed/3 stages, 18-bit acc/8 stages) checked every cycle against an arithmetic model.
module tb_tri2d_mul_acc_pipe;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n, ce, in_valid, acc_mode, acc_first;
  logic [11:0] din0;
  logic [4:0]  din1;
  logic        ov0, ov1, ov2, of0, of1, of2;
  logic [23:0] d0, d1;
  logic [17:0] d2;

  always #5 clk = ~clk;

  tri2d_mul_acc_pipe u_def (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .acc_mode(acc_mode),
    .acc_first(acc_first), .din0(din0), .din1(din1), .out_valid(ov0), .dout(d0), .ovf(of0));

  tri2d_mul_acc_pipe #(.A_SIGNED(1), .B_SIGNED(1), .NUM_STAGE(3)) u_sgn (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .acc_mode(acc_mode),
    .acc_first(acc_first), .din0(din0), .din1(din1), .out_valid(ov1), .dout(d1), .ovf(of1));

  tri2d_mul_acc_pipe #(.ACC_WIDTH(18), .NUM_STAGE(8)) u_a18 (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .acc_mode(acc_mode),
    .acc_first(acc_first), .din0(din0), .din1(din1), .out_valid(ov2), .dout(d2), .ovf(of2));

  typedef struct {bit v; bit m; bit f; longint a; longint b;} smp_t;

  int     ns[NI] = '{4, 3, 8};
  bit     sg[NI] = '{0, 1, 0};
  int     aw[NI] = '{24, 24, 18};
  smp_t   pipe[NI][8];
  bit     m_ov[NI], m_ovf[NI];
  longint m_dout[NI], m_acc[NI];
  int     ncomp = 0, nfail = 0;

  function automatic longint sx(longint v, int w);
    return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction

  function automatic longint umod(longint v, longint m);
    return ((v % m) + m) % m;
  endfunction

  task automatic retire(int k, smp_t s);
    longint mod, pa, pb, pu, t;
    m_ov[k] = s.v;
    if (!s.v) return;
    mod = longint'(1) << aw[k];
    pa  = sg[k] ? sx(s.a, 12) : s.a;
    pb  = sg[k] ? sx(s.b, 5) : s.b;
    pu  = umod(pa * pb, mod);
    if (!s.m) begin
      m_dout[k] = pu;
    end else if (s.f) begin
      m_acc[k] = pu; m_ovf[k] = 0; m_dout[k] = pu;
    end else begin
      if (sg[k]) begin
        t = sx(m_acc[k], aw[k]) + sx(pu, aw[k]);
        if (t > mod / 2 - 1 || t < -(mod / 2)) m_ovf[k] = 1;
      end else begin
        t = m_acc[k] + pu;
        if (t >= mod) m_ovf[k] = 1;
      end
      m_acc[k]  = umod(t, mod);
      m_dout[k] = m_acc[k];
    end
  endtask

  task automatic model_edge();
    smp_t fin;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 8; j++) pipe[k][j] = '{0, 0, 0, 0, 0};
        m_ov[k] = 0; m_ovf[k] = 0; m_dout[k] = 0; m_acc[k] = 0;
      end else if (ce) begin
        fin = pipe[k][ns[k]-2];
        for (int j = ns[k] - 2; j > 0; j--) pipe[k][j] = pipe[k][j-1];
        pipe[k][0] = '{in_valid, acc_mode, acc_first, longint'(din0), longint'(din1)};
        retire(k, fin);
      end
    end
  endtask

  task automatic chk(string tag, longint act, longint exp);
    ncomp++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    longint ad[NI];
    bit     aov[NI], aof[NI];
    @(posedge clk);
    model_edge();
    #1;
    ad[0] = longint'(d0); ad[1] = longint'(d1); ad[2] = longint'(d2);
    aov   = '{ov0, ov1, ov2};
    aof   = '{of0, of1, of2};
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("cfg%0d_out_valid", k), longint'(aov[k]), longint'(m_ov[k]));
      chk($sformatf("cfg%0d_dout", k), ad[k], m_dout[k]);
      chk($sformatf("cfg%0d_ovf", k), longint'(aof[k]), longint'(m_ovf[k]));
    end
  endtask

  task automatic drive(bit v, bit m, bit f, int a, int b);
    in_valid = v; acc_mode = m; acc_first = f; din0 = 12'(a); din1 = 5'(b);
    tick();
  endtask

  task automatic idle(int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 8; j++) pipe[k][j] = '{0, 0, 0, 0, 0};
      m_ov[k] = 0; m_ovf[k] = 0; m_dout[k] = 0; m_acc[k] = 0;
    end
    rst_n = 0; ce = 1; in_valid = 0; acc_mode = 0; acc_first = 0; din0 = 0; din1 = 0;

    // reset state
    idle(2);
    chk("reset_dout", longint'(d0), 0);
    chk("reset_valid", longint'(ov0), 0);
    chk("reset_ovf", longint'(of0), 0);
    rst_n = 1;

    // plain multiply, 4-edge latency, single-cycle valid, dout held
    drive(1, 0, 0, 4095, 31);
    idle(3);
    chk("mul_max_dout", longint'(d0), 126945);
    chk("mul_max_valid", longint'(ov0), 1);
    idle(1);
    chk("mul_bubble_valid", longint'(ov0), 0);
    chk("mul_bubble_hold", longint'(d0), 126945);
    idle(8);

    // signed back-to-back on the 3-stage signed instance
    drive(1, 0, 0, 'hFFF, 'h1F);
    drive(1, 0, 0, 'h800, 'h0F);
    idle(1);
    chk("sgn_m1xm1", longint'(d1), 1);
    idle(1);
    chk("sgn_min_x15", longint'(d1), 64'hFF8800);
    idle(8);

    // accumulate stream
    drive(1, 1, 1, 3, 4);
    drive(1, 1, 0, 5, 6);
    drive(1, 1, 0, 7, 8);
    idle(1); chk("acc_12", longint'(d0), 12);
    idle(1); chk("acc_42", longint'(d0), 42);
    idle(1); chk("acc_98", longint'(d0), 98);

    // reset with samples in flight
    drive(1, 1, 0, 9, 9);
    drive(1, 0, 0, 5, 5);
    rst_n = 0;
    idle(1);
    chk("midreset_dout", longint'(d0), 0);
    chk("midreset_valid", longint'(ov0), 0);
    chk("midreset_ovf", longint'(of0), 0);
    rst_n = 1;
    idle(8);
    drive(1, 1, 0, 1, 1);
    idle(3); chk("acc_after_reset", longint'(d0), 1);
    drive(1, 1, 1, 2, 2);
    idle(3); chk("acc_restart", longint'(d0), 4);
    idle(8);

    // 18-bit accumulator overflow on the 8-stage instance
    drive(1, 1, 1, 4095, 31);
    drive(1, 1, 0, 4095, 31);
    drive(1, 1, 0, 4095, 31);
    idle(5); chk("a18_first", longint'(d2), 126945);
    idle(1); chk("a18_second", longint'(d2), 253890);
    chk("a18_no_ovf", longint'(of2), 0);
    idle(1); chk("a18_wrap", longint'(d2), 118691);
    chk("a18_ovf_set", longint'(of2), 1);
    idle(3); chk("a18_ovf_sticky", longint'(of2), 1);
    drive(1, 1, 1, 1, 1);
    idle(7);
    chk("a18_ovf_cleared", longint'(of2), 0);
    chk("a18_restart", longint'(d2), 1);
    idle(8);

    // ce freeze with two samples in flight
    drive(1, 0, 0, 100, 7);
    drive(1, 0, 0, 200, 9);
    ce = 0;
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 4095, 31);
    ce = 1;
    idle(1);
    chk("ce_frozen_valid", longint'(ov0), 0);
    idle(1); chk("ce_first", longint'(d0), 700);
    chk("ce_first_valid", longint'(ov0), 1);
    idle(1); chk("ce_second", longint'(d0), 1800);
    idle(8);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ce    = ($urandom % 8) != 0;
      rst_n = ($urandom % 60) != 0;
      drive(1'($urandom), 1'($urandom), ($urandom % 4) == 0,
            int'($urandom % 4096), int'($urandom % 32));
    end
    rst_n = 1; ce = 1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
